// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the Maxnet input-side blocks.
package maxnet_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 4;

   typedef logic [DEF_WIDTH-1:0] act_t;

   typedef enum logic [1:0] {FILL, START, WAIT} buf_state_t;

endpackage

// File: rtl/maxnet_input_buffer_if.sv
// Host-to-buffer activation stream (valid/ready).
interface maxnet_input_buffer_if #(
   parameter int unsigned WIDTH = maxnet_pkg::DEF_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/maxnet_act_bank.sv
// DEPTH x WIDTH activation register file: one synchronous write port, one combinational read port.
module maxnet_act_bank #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     mem <= '{default: '0};
      else if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/maxnet_input_buffer.sv
// Write-side feeder for the Maxnet CU: collects a frame of activations, pulses start, holds it until done.
// Optional double buffering with MAXNET_BUF_PINGPONG_EN.
module maxnet_input_buffer
   import maxnet_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   maxnet_input_buffer_if.slave  host,
   input  logic                  clr,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  start,
   input  logic                  done,
   output logic                  busy,
   output logic [7:0]            frame_cnt
);

   buf_state_t        state;
   logic [ADDR_W-1:0] wr_cnt;
   logic              ready_q;
   logic              xfer, wr_en, last;

   assign host.in_ready = ready_q;
   assign xfer  = host.in_valid && ready_q;
   assign wr_en = xfer && !clr;
   assign last  = wr_en && (wr_cnt == ADDR_W'(DEPTH - 1));

`ifdef MAXNET_BUF_PINGPONG_EN
   logic             wr_bank, pend;
   logic [WIDTH-1:0] rdata0, rdata1;

   // state tracks CU ownership only; the fill side runs independently until a full frame has to wait
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         wr_cnt    <= '0;
         ready_q   <= 1'b0;
         start     <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
         wr_bank   <= 1'b0;
         pend      <= 1'b0;
      end else begin
         start <= 1'b0;
         if (!pend) ready_q <= 1'b1;
         case (state)
            FILL:  ;
            START: state <= WAIT;
            WAIT: if (done) begin
               frame_cnt <= frame_cnt + 8'd1;
               if (pend) begin
                  wr_bank <= !wr_bank;
                  pend    <= 1'b0;
                  ready_q <= 1'b1;
                  start   <= 1'b1;
                  state   <= START;
               end else begin
                  busy  <= 1'b0;
                  state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
         // last implies ready_q=1, hence pend=0, so these writes never collide with the swap above
         if (clr) wr_cnt <= '0;
         else if (last) begin
            wr_cnt <= '0;
            if (state == FILL || (state == WAIT && done)) begin
               wr_bank <= !wr_bank;
               start   <= 1'b1;
               busy    <= 1'b1;
               state   <= START;
            end else begin
               pend    <= 1'b1;
               ready_q <= 1'b0;
            end
         end else if (xfer) wr_cnt <= wr_cnt + 1'b1;
      end
   end

   maxnet_act_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
      .clk(clk), .rst(rst), .we(wr_en && !wr_bank), .waddr(wr_cnt), .wdata(host.in_data),
      .raddr(rd_addr), .rdata(rdata0)
   );
   maxnet_act_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
      .clk(clk), .rst(rst), .we(wr_en && wr_bank), .waddr(wr_cnt), .wdata(host.in_data),
      .raddr(rd_addr), .rdata(rdata1)
   );

   assign rd_data = wr_bank ? rdata0 : rdata1;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         wr_cnt    <= '0;
         ready_q   <= 1'b0;
         start     <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         start <= 1'b0;
         case (state)
            FILL: begin
               ready_q <= 1'b1;
               if (clr) wr_cnt <= '0;
               else if (last) begin
                  wr_cnt  <= '0;
                  ready_q <= 1'b0;
                  start   <= 1'b1;
                  busy    <= 1'b1;
                  state   <= START;
               end else if (xfer) wr_cnt <= wr_cnt + 1'b1;
            end
            START: state <= WAIT;
            WAIT: if (done) begin
               busy      <= 1'b0;
               ready_q   <= 1'b1;
               frame_cnt <= frame_cnt + 8'd1;
               state     <= FILL;
            end
            default: state <= FILL;
         endcase
      end
   end

   maxnet_act_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk(clk), .rst(rst), .we(wr_en), .waddr(wr_cnt), .wdata(host.in_data),
      .raddr(rd_addr), .rdata(rd_data)
   );
`endif

endmodule
